// File: rtl/dmem_bank_ctrl.sv
// dmem_bank_ctrl: banked data memory with read-modify-write sub-word stores and lane-extracted loads.
// Define DMEM_SIGN_EXT_EN to add unsigned_i and sign-extending sub-word loads.
module dmem_bank_ctrl #(
  parameter int NBANKS   = 4,
  parameter int BANK_AW  = 16,
  parameter int BANK_LSB = 18
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  byte_mode_i,
`ifdef DMEM_SIGN_EXT_EN
  input  logic        unsigned_i,
`endif
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] data_o,
  output logic        fault_o
);
  localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1;
  typedef enum logic {IDLE, MERGE} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] bank_sel, bank_q, bank_d, ram_bank;
  logic [BANK_AW-1:0] waddr_q, waddr_d, ram_addr;
  logic [1:0] lane_q, lane_d, mode_q, mode_d;
  logic [15:0] wdata_q, wdata_d;
  logic uns_q, uns_d, rvalid_q, rvalid_d, fault_q, fault_d;
  logic [31:0] last_q, last_d, rd, merged, ram_wdata;
  logic [NBANKS-1:0][31:0] rd_all;
  logic ram_en, ram_we, mis, acc, sub;
  logic [7:0] b8;
  logic [15:0] h16;
  logic unused_addr;
  assign unused_addr = ^address_i;
  assign bank_sel = NBANKS > 1 ? address_i[BANK_LSB +: BW] : '0;
  assign ready_o  = state_q == IDLE;
  assign rvalid_o = rvalid_q;
  assign fault_o  = fault_q;
  assign rd       = rd_all[bank_q];
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [31:0] mem [2**BANK_AW];
    logic [31:0] rdata;
    always_ff @(posedge CLK) begin
      if (!RST && ram_en && ram_bank == BW'(b)) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else rdata <= mem[ram_addr];
      end
    end
    assign rd_all[b] = rdata;
  end
  always_comb begin
    b8  = rd[8*lane_q +: 8];
    h16 = rd[16*lane_q[1] +: 16];
    merged = rd;
    if (mode_q == 2'b10) merged[8*lane_q +: 8] = wdata_q[7:0];
    else merged[16*lane_q[1] +: 16] = wdata_q;
    data_o = !rvalid_q ? last_q :
             mode_q == 2'b10 ? {{24{!uns_q && b8[7]}}, b8} :
             mode_q == 2'b01 ? {{16{!uns_q && h16[15]}}, h16} : rd;
    last_d = data_o;
  end
  always_comb begin
    sub = byte_mode_i == 2'b01 || byte_mode_i == 2'b10;
    mis = byte_mode_i == 2'b01 ? address_i[0] : !sub && address_i[1:0] != 2'b00;
    acc = req_i && state_q == IDLE && !mis;
    state_d = state_q;
    bank_d = bank_q;
    waddr_d = waddr_q;
    lane_d = lane_q;
    mode_d = mode_q;
    wdata_d = wdata_q;
    uns_d = uns_q;
    rvalid_d = 1'b0;
    fault_d = req_i && state_q == IDLE && mis;
    ram_en = 1'b0;
    ram_we = 1'b0;
    ram_bank = bank_sel;
    ram_addr = address_i[BANK_AW+1:2];
    ram_wdata = data_i;
    if (state_q == MERGE) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
      ram_bank = bank_q;
      ram_addr = waddr_q;
      ram_wdata = merged;
      state_d = IDLE;
    end else if (acc) begin
      ram_en = 1'b1;
      ram_we = we_i && !sub;
      bank_d = bank_sel;
      waddr_d = address_i[BANK_AW+1:2];
      lane_d = address_i[1:0];
      mode_d = byte_mode_i;
      wdata_d = data_i[15:0];
`ifdef DMEM_SIGN_EXT_EN
      uns_d = unsigned_i;
`else
      uns_d = 1'b1;
`endif
      rvalid_d = !we_i;
      state_d = we_i && sub ? MERGE : IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rvalid_q <= 1'b0;
      fault_q <= 1'b0;
      last_q <= '0;
      bank_q <= '0;
      waddr_q <= '0;
      lane_q <= '0;
      mode_q <= '0;
      wdata_q <= '0;
      uns_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rvalid_q <= rvalid_d;
      fault_q <= fault_d;
      last_q <= last_d;
      bank_q <= bank_d;
      waddr_q <= waddr_d;
      lane_q <= lane_d;
      mode_q <= mode_d;
      wdata_q <= wdata_d;
      uns_q <= uns_d;
    end
  end
endmodule
